uart_frame_shifter: RTL and testbench

Parametrised full-duplex UART frame shift register for the UART module. A single load starts a frame: the block serialises a start bit, DATA_W data bits (LSB first), an optional parity bit and STOP_BITS stop bits on serial_o. In parallel it captures the same number of bits from serial_i, one bit per shift strobe. At end of frame it presents the received data with frame and parity status. The baud/oversampling logic supplies the `en` strobe.

---
 rtl/uart_frame_shifter_if.sv | 26 ++
 rtl/uart_frame_shifter.sv | 105 ++++++++++
 tb/tb_uart_frame_shifter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_shifter_if.sv
// Parallel/serial signal bundle for uart_frame_shifter.
// master = the controller that loads frames and drives the line; slave = the shifter.
interface uart_frame_shifter_if #(
   parameter int DATA_W = 8
);
   logic              ld;
   logic              en;
   logic              serial_i;
   logic [DATA_W-1:0] dat_i;
   logic [DATA_W-1:0] dat_o;
   logic              serial_o;
   logic              busy;
   logic              done;
   logic              frame_err;
   logic              par_err;

   modport master (
      output ld, en, serial_i, dat_i,
      input  dat_o, serial_o, busy, done, frame_err, par_err
   );

   modport slave (
      input  ld, en, serial_i, dat_i,
      output dat_o, serial_o, busy, done, frame_err, par_err
   );
endinterface

// File: rtl/uart_frame_shifter.sv
// Full-duplex UART frame shifter: transmits one frame on serial_o while capturing one on serial_i.
// Optional even parity bit is enabled by defining UART_FRAME_PARITY_EN.
module uart_frame_shifter #(
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1
) (
   input logic                  clk,
   input logic                  arst,
   input logic                  rst,
   uart_frame_shifter_if.slave  bus
);
`ifdef UART_FRAME_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME_W = 1 + DATA_W + PAR + STOP_BITS;
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state, state_nxt;
   logic [FRAME_W-1:0] sr, sr_nxt, sr_shift, sr_load;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               frame_end;
   logic [DATA_W-1:0]  dat_q;
   logic               done_q, frame_err_q, par_err_q;
   logic               frame_err_nxt, par_err_nxt;

`ifdef UART_FRAME_PARITY_EN
   assign sr_load     = {{STOP_BITS{1'b1}}, ^bus.dat_i, bus.dat_i, 1'b0};
   assign par_err_nxt = (^sr_shift[DATA_W:1]) ^ sr_shift[DATA_W+1];
`else
   assign sr_load     = {{STOP_BITS{1'b1}}, bus.dat_i, 1'b0};
   assign par_err_nxt = 1'b0;
`endif

   assign sr_shift      = {bus.serial_i, sr[FRAME_W-1:1]};
   // Bad start bit or any stop bit not at mark level.
   assign frame_err_nxt = sr_shift[0] | ~(&sr_shift[FRAME_W-1 -: STOP_BITS]);

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      cnt_nxt   = cnt;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ld) begin
               sr_nxt    = sr_load;
               cnt_nxt   = CNT_W'(FRAME_W);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.en) begin
               sr_nxt  = sr_shift;
               cnt_nxt = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state_nxt = IDLE;
                  frame_end = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state       <= IDLE;
         sr          <= '1;
         cnt         <= '0;
         dat_q       <= '0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
         par_err_q   <= 1'b0;
      end else if (rst) begin
         state       <= IDLE;
         sr          <= '1;
         cnt         <= '0;
         dat_q       <= '0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
         par_err_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         sr     <= sr_nxt;
         cnt    <= cnt_nxt;
         done_q <= frame_end;
         if (frame_end) begin
            dat_q       <= sr_shift[DATA_W:1];
            frame_err_q <= frame_err_nxt;
            par_err_q   <= par_err_nxt;
         end
      end
   end

   assign bus.dat_o     = dat_q;
   assign bus.done      = done_q;
   assign bus.frame_err = frame_err_q;
   assign bus.par_err   = par_err_q;
   assign bus.busy      = (state == SHIFT);
   assign bus.serial_o  = sr[0];
endmodule

// File: tb/tb_uart_frame_shifter.sv
// Self-checking bench for uart_frame_shifter: directed table, reset/abort sequences and
// randomized frames checked against a bit-list reference model.
module tb_uart_frame_shifter;
   localparam int DATA_W = 8;
`ifdef UART_FRAME_PARITY_EN
   localparam int PAR = 1;
   localparam int STOP_BITS = 2;
`else
   localparam int PAR = 0;
   localparam int STOP_BITS = 1;
`endif
   localparam int FRAME_W = 1 + DATA_W + PAR + STOP_BITS;
   localparam bit PB = (PAR == 1);

   logic clk = 1'b0;
   logic arst = 1'b1;
   logic rst = 1'b0;
   logic loop = 1'b0;
   logic flip = 1'b0;
   logic rx_bit = 1'b1;

   int n_chk = 0;
   int n_fail = 0;

   uart_frame_shifter_if #(.DATA_W(DATA_W)) bus ();

   uart_frame_shifter #(.DATA_W(DATA_W), .STOP_BITS(STOP_BITS)) dut (
      .clk (clk),
      .arst(arst),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always_comb bus.serial_i = loop ? (bus.serial_o ^ flip) : rx_bit;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the frame as an ordered list of line bits, start bit first.
   function automatic logic [FRAME_W-1:0] tx_model(input logic [DATA_W-1:0] d);
      bit q[$];
      logic [FRAME_W-1:0] v;
      q.push_back(1'b0);
      for (int i = 0; i < DATA_W; i++) q.push_back(d[i]);
      if (PB) begin
         int ones = 0;
         for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
         q.push_back(ones % 2 == 1);
      end
      for (int i = 0; i < STOP_BITS; i++) q.push_back(1'b1);
      for (int i = 0; i < FRAME_W; i++) v[i] = q[i];
      return v;
   endfunction

   task automatic load(input logic [DATA_W-1:0] d, input bit with_en);
      bus.ld = 1'b1;
      bus.dat_i = d;
      bus.en = with_en;
      @(posedge clk); #1;
      bus.ld = 1'b0;
      chk("load_busy", int'(bus.busy), 1);
      chk("load_start_bit", int'(bus.serial_o), 0);
      chk("load_no_done", int'(bus.done), 0);
   endtask

   // Runs FRAME_W en strobes; lp selects loopback, else rx bits come from rx_pat.
   task automatic shift(input logic [DATA_W-1:0] d, input bit lp, input logic [FRAME_W-1:0] rx_pat,
                        input int flip_idx, input int ld_mid_idx, input logic [DATA_W-1:0] exp_dat,
                        input bit exp_ferr, input bit exp_perr);
      logic [FRAME_W-1:0] tx;
      tx = tx_model(d);
      loop = lp;
      for (int i = 0; i < FRAME_W; i++) begin
         chk($sformatf("serial_o[%0d]", i), int'(bus.serial_o), int'(tx[i]));
         bus.en = 1'b1;
         flip = (i == flip_idx);
         rx_bit = rx_pat[i];
         if (i == ld_mid_idx) begin
            bus.ld = 1'b1;
            bus.dat_i = ~d;
         end
         @(posedge clk); #1;
         bus.ld = 1'b0;
         flip = 1'b0;
         if (i < FRAME_W - 1) begin
            chk("mid_busy", int'(bus.busy), 1);
            chk("mid_done", int'(bus.done), 0);
         end
      end
      chk("done", int'(bus.done), 1);
      chk("busy_fall", int'(bus.busy), 0);
      chk("dat_o", int'(bus.dat_o), int'(exp_dat));
      chk("frame_err", int'(bus.frame_err), int'(exp_ferr));
      chk("par_err", int'(bus.par_err), int'(exp_perr));
      loop = 1'b0;
   endtask

   task automatic tail;
      bus.en = 1'b1;
      @(posedge clk); #1;
      chk("done_one_cycle", int'(bus.done), 0);
      chk("idle_busy", int'(bus.busy), 0);
      bus.en = 1'b0;
   endtask

   typedef struct {
      logic [DATA_W-1:0] dat;
      int                flip_idx;
      bit                with_en;
      logic [DATA_W-1:0] exp_dat;
      bit                exp_ferr;
      bit                exp_perr;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [FRAME_W-1:0] rxp;
      logic [DATA_W-1:0]  d, ed;
      bit                 ef, ep;
      int                 ones;

      tbl[0] = '{8'h3C, -1, 1'b0, 8'h3C, 1'b0, 1'b0};
      tbl[1] = '{8'hA5, FRAME_W-1, 1'b0, 8'hA5, 1'b1, 1'b0};
      tbl[2] = '{8'hA5, 0, 1'b1, 8'hA5, 1'b1, 1'b0};
      tbl[3] = '{8'h5A, 1, 1'b0, 8'h5B, 1'b0, PB};
      tbl[4] = '{8'h07, DATA_W+1, 1'b1, 8'h07, !PB, PB};
      tbl[5] = '{8'hFF, -1, 1'b1, 8'hFF, 1'b0, 1'b0};
      tbl[6] = '{8'h00, DATA_W, 1'b0, 8'h80, 1'b0, PB};

      bus.ld = 1'b0;
      bus.en = 1'b0;
      bus.dat_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_dat_o", int'(bus.dat_o), 0);
      chk("rst_ferr", int'(bus.frame_err), 0);
      chk("rst_perr", int'(bus.par_err), 0);
      chk("rst_serial_o", int'(bus.serial_o), 1);
      arst = 1'b0;
      bus.en = 1'b1;
      @(posedge clk); #1;
      chk("idle_en_ignored", int'(bus.serial_o), 1);
      chk("idle_en_busy", int'(bus.busy), 0);
      bus.en = 1'b0;

      foreach (tbl[k]) begin
         load(tbl[k].dat, tbl[k].with_en);
         shift(tbl[k].dat, 1'b1, '1, tbl[k].flip_idx, -1, tbl[k].exp_dat, tbl[k].exp_ferr, tbl[k].exp_perr);
         tail();
      end

      // ld during a frame is ignored; then a new ld in the done cycle is accepted.
      load(8'h3C, 1'b0);
      shift(8'h3C, 1'b1, '1, -1, 3, 8'h3C, 1'b0, 1'b0);
      load(8'h81, 1'b0);
      shift(8'h81, 1'b1, '1, -1, -1, 8'h81, 1'b0, 1'b0);
      tail();

      // Synchronous clear mid-frame aborts without a done pulse.
      load(8'h96, 1'b0);
      loop = 1'b1;
      bus.en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_serial_o", int'(bus.serial_o), 1);
      chk("abort_dat_o", int'(bus.dat_o), 0);
      chk("abort_done", int'(bus.done), 0);
      for (int i = 0; i < FRAME_W + 2; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done", int'(bus.done), 0);
         chk("abort_idle", int'(bus.busy), 0);
      end
      bus.en = 1'b0;
      loop = 1'b0;

      // Random frames against the reference model.
      for (int r = 0; r < 24; r++) begin
         d = DATA_W'($urandom);
         rxp = FRAME_W'($urandom);
         if (r % 2 == 0) begin
            rxp[0] = 1'b0;
            for (int s = 0; s < STOP_BITS; s++) rxp[FRAME_W-1-s] = 1'b1;
         end
         for (int i = 0; i < DATA_W; i++) ed[i] = rxp[i+1];
         ef = (rxp[0] != 1'b0);
         for (int s = 0; s < STOP_BITS; s++) if (rxp[FRAME_W-1-s] != 1'b1) ef = 1'b1;
         ones = 0;
         for (int i = 0; i < DATA_W; i++) ones += int'(ed[i]);
         ep = PB ? ((ones % 2 == 1) != rxp[DATA_W+1]) : 1'b0;
         load(d, bit'($urandom_range(1)));
         shift(d, 1'b0, rxp, -1, -1, ed, ef, ep);
         tail();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
